// File: rtl/nibble_serial_add_seq.sv
// -----------------------------------------------------------------------------
// nibble_serial_add_seq
//
// Purpose:
//   Sequencer that builds a WIDTH-bit addition one nibble per clock around an
//   external 4-bit full adder. Operands are accepted on a valid/ready input
//   channel. The sequencer steps the adder through the nibbles from least to
//   most significant, carrying the adder's carry-out into the next nibble.
//   The finished sum is then presented on a valid/ready output channel.
//
// Parameters:
//   WIDTH    operand/result width in bits (multiple of 4, at least 4)
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   in_valid     operand channel valid
//   in_ready     operand channel ready (high only while idle)
//   op_a, op_b   WIDTH-bit operands
//   op_cin       carry-in for the whole addition
//   add_a        nibble of A presented to the external adder
//   add_b        nibble of B presented to the external adder
//   add_cin      carry presented to the external adder
//   add_sum      adder sum (combinational from add_a/add_b/add_cin)
//   add_cout     adder carry-out
//   out_valid    result channel valid
//   out_ready    result channel ready
//   result       op_a + op_b + op_cin, modulo 2^WIDTH
//   result_cout  carry out of the most significant nibble
//   busy         high while an addition is running or waiting to be taken
// -----------------------------------------------------------------------------
module nibble_serial_add_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_cout,
  output logic             busy
);

  // Number of nibble steps; derived, not a port-level parameter.
  localparam int NIBBLES = WIDTH / 4;

  // The nibble index needs at least one bit even when there is one nibble.
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t             state_r;
  state_t             state_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               carry_r;
  logic [IDX_W-1:0]   idx_r;
  logic [WIDTH-1:0]   result_r;
  logic               result_cout_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               busy_r;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic               accept_s;
  logic               last_s;
  logic [IDX_W+1:0]   shift_s;
  logic [WIDTH-1:0]   nib_mask_s;
  logic [WIDTH-1:0]   nib_ins_s;
  logic [3:0]         add_a_s;
  logic [3:0]         add_b_s;
  logic               add_cin_s;

  // Bit offset of the current nibble: idx * 4.
  assign shift_s    = {idx_r, 2'b00};

  // Lane mask and aligned adder sum used to overwrite just the current nibble.
  assign nib_mask_s = WIDTH'(4'hF) << shift_s;
  assign nib_ins_s  = WIDTH'(add_sum) << shift_s;

  // Final nibble step of the RUN phase.
  assign last_s     = (idx_r == LAST_IDX) ? 1'b1 : 1'b0;

  // Next-state decode for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          state_s  = RUN;
          accept_s = 1'b1;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (out_valid_r && out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Adder drive: only registered values feed the adder, and only in RUN, so
  // there is no combinational loop through the external adder.
  always_comb begin
    add_a_s   = 4'h0;
    add_b_s   = 4'h0;
    add_cin_s = 1'b0;
    if (state_r == RUN) begin
      add_a_s   = 4'(a_r >> shift_s);
      add_b_s   = 4'(b_r >> shift_s);
      add_cin_s = carry_r;
    end else begin
      add_a_s   = 4'h0;
      add_b_s   = 4'h0;
      add_cin_s = 1'b0;
    end
  end

  // Sequencer state, handshake flags and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      a_r           <= {WIDTH{1'b0}};
      b_r           <= {WIDTH{1'b0}};
      carry_r       <= 1'b0;
      idx_r         <= IDX_ZERO;
      result_r      <= {WIDTH{1'b0}};
      result_cout_r <= 1'b0;
      in_ready_r    <= 1'b1;
      out_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r     <= state_s;
      // Handshake flags are registered copies of the next-state decode so
      // they change cleanly on the clock edge together with the state.
      in_ready_r  <= (state_s == IDLE) ? 1'b1 : 1'b0;
      out_valid_r <= (state_s == DONE) ? 1'b1 : 1'b0;
      busy_r      <= (state_s != IDLE) ? 1'b1 : 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r           <= op_a;
            b_r           <= op_b;
            carry_r       <= op_cin;
            idx_r         <= IDX_ZERO;
            result_r      <= {WIDTH{1'b0}};
            result_cout_r <= 1'b0;
          end
        end
        RUN: begin
          result_r <= (result_r & ~nib_mask_s) | nib_ins_s;
          carry_r  <= add_cout;
          if (last_s) begin
            // The top carry goes to result_cout only; it never wraps back.
            result_cout_r <= add_cout;
            idx_r         <= IDX_ZERO;
          end else begin
            idx_r         <= idx_r + IDX_ONE;
          end
        end
        DONE: begin
          // Result is held until the consumer takes it and beyond, until
          // the next accept clears it.
          result_r      <= result_r;
          result_cout_r <= result_cout_r;
        end
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output wiring
  // ---------------------------------------------------------------------------
  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign busy        = busy_r;
  assign result      = result_r;
  assign result_cout = result_cout_r;
  assign add_a       = add_a_s;
  assign add_b       = add_b_s;
  assign add_cin     = add_cin_s;

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_add_seq
//
// Bench for the nibble-serial add sequencer. A behavioural 4-bit adder is
// wired to the add_* ports; expected sums come from plain (WIDTH+1)-bit
// arithmetic.
// -----------------------------------------------------------------------------
module tb_nibble_serial_add_seq;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_cin;
  logic [3:0]       add_sum;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             result_cout;
  logic             busy;

  int errors = 0;
  int checks = 0;

  nibble_serial_add_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_cout(result_cout), .busy(busy)
  );

  // External 4-bit full adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

  always #5 clk = ~clk;

  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic c);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    return s;
  endfunction

  // Offer operands until accepted (bounded). Returns at edge+1 after accept.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic c, output bit ok);
    bit rdy;
    op_a = a; op_b = b; op_cin = c; in_valid = 1'b1; ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) begin ok = 1'b1; break; end
    end
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid is seen (bounded).
  task automatic wait_valid(output int n, output bit ok);
    n = 0; ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (out_valid) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({in_ready, out_valid, busy, result_cout, result, add_a, add_b, add_cin} !==
        {1'b1, 1'b0, 1'b0, 1'b0, {WIDTH{1'b0}}, 4'h0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b vld=%b busy=%b cout=%b res=%h a=%h b=%h cin=%b, expected 1 0 0 0 0 0 0 0",
               in_ready, out_valid, busy, result_cout, result, add_a, add_b, add_cin);
    end
  endtask

  task automatic test_basic();
    bit ok; int n;
    out_ready = 1'b1;
    send(16'h0001, 16'h0002, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_accept: got no accept, expected accept"); end
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL basic_run_flags: got rdy=%b busy=%b, expected 0 1", in_ready, busy);
    end
    wait_valid(n, ok);
    checks++;
    if (!ok || n != NIB) begin
      errors++; $display("FAIL basic_latency: got %0d edges (seen=%0b), expected %0d", n, ok, NIB);
    end
    checks++;
    if ({result_cout, result} !== 17'h00003) begin
      errors++; $display("FAIL basic_result: got %b_%h, expected 0_0003", result_cout, result);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || result !== 16'h0003) begin
      errors++; $display("FAIL basic_release: got vld=%b rdy=%b busy=%b res=%h, expected 0 1 0 0003",
                         out_valid, in_ready, busy, result);
    end
  endtask

  // Traces add_* per RUN cycle; operand bus is scrambled after accept.
  task automatic test_sequence();
    logic [WIDTH-1:0] ta[4];
    logic [WIDTH-1:0] tb[4];
    logic             tc[4];
    logic [3:0]       ea, eb;
    logic             ec;
    logic [4:0]       t;
    logic [WIDTH:0]   exp;
    bit ok;
    ta[0] = 16'h1234; tb[0] = 16'h0F0F; tc[0] = 1'b0;
    for (int i = 1; i < 4; i++) begin
      ta[i] = WIDTH'($urandom); tb[i] = WIDTH'($urandom); tc[i] = 1'($urandom);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(ta[i], tb[i], tc[i], ok);
      op_a = WIDTH'($urandom); op_b = WIDTH'($urandom); op_cin = ~tc[i];
      ec = tc[i];
      for (int k = 0; k < NIB; k++) begin
        ea = 4'(ta[i] >> (4 * k));
        eb = 4'(tb[i] >> (4 * k));
        checks++;
        if (add_a !== ea || add_b !== eb || add_cin !== ec) begin
          errors++;
          $display("FAIL seq_nibble%0d case%0d: got a=%h b=%h cin=%b, expected a=%h b=%h cin=%b",
                   k, i, add_a, add_b, add_cin, ea, eb, ec);
        end
        t  = {1'b0, ea} + {1'b0, eb} + {4'b0000, ec};
        ec = t[4];
        @(posedge clk); #1;
      end
      exp = ref_add(ta[i], tb[i], tc[i]);
      checks++;
      if (out_valid !== 1'b1 || {result_cout, result} !== exp) begin
        errors++;
        $display("FAIL seq_result case%0d: got vld=%b %b_%h, expected 1 %b_%h",
                 i, out_valid, result_cout, result, exp[WIDTH], exp[WIDTH-1:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_carry();
    logic [WIDTH-1:0] ca[2];
    logic [WIDTH-1:0] cb[2];
    logic             cc[2];
    bit ok; int n;
    ca[0] = 16'hFFFF; cb[0] = 16'h0001; cc[0] = 1'b0;
    ca[1] = 16'h5555; cb[1] = 16'hAAAA; cc[1] = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send(ca[i], cb[i], cc[i], ok);
      wait_valid(n, ok);
      checks++;
      if (!ok || {result_cout, result} !== 17'h10000) begin
        errors++; $display("FAIL carry case%0d: got %b_%h (seen=%0b), expected 1_0000",
                           i, result_cout, result, ok);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a, b;
    logic c;
    logic [WIDTH:0] exp;
    bit ok; int n; int stall;
    for (int i = 0; i < 20; i++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); c = 1'($urandom);
      exp = ref_add(a, b, c);
      out_ready = 1'b0;
      send(a, b, c, ok);
      op_a = WIDTH'($urandom); op_b = WIDTH'($urandom);
      wait_valid(n, ok);
      checks++;
      if (!ok || n != NIB || {result_cout, result} !== exp) begin
        errors++;
        $display("FAIL random%0d: got %b_%h after %0d edges, expected %b_%h after %0d",
                 i, result_cout, result, n, exp[WIDTH], exp[WIDTH-1:0], NIB);
      end
      stall = $urandom_range(0, 3);
      repeat (stall) begin @(posedge clk); #1; end
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH:0] e1, e2;
    bit ok; int n;
    e1 = ref_add(16'hBEEF, 16'h1111, 1'b1);
    e2 = ref_add(16'h0F00, 16'hF100, 1'b0);
    out_ready = 1'b0;
    send(16'hBEEF, 16'h1111, 1'b1, ok);
    wait_valid(n, ok);
    op_a = 16'h0F00; op_b = 16'hF100; op_cin = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {result_cout, result} !== e1) begin
        errors++;
        $display("FAIL bp_hold cycle%0d: got vld=%b rdy=%b %b_%h, expected 1 0 %b_%h",
                 k, out_valid, in_ready, result_cout, result, e1[WIDTH], e1[WIDTH-1:0]);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || {result_cout, result} !== e1) begin
      errors++; $display("FAIL bp_release: got vld=%b rdy=%b %b_%h, expected 0 1 %b_%h",
                         out_valid, in_ready, result_cout, result, e1[WIDTH], e1[WIDTH-1:0]);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL bp_second_accept: got rdy=%b busy=%b, expected 0 1", in_ready, busy);
    end
    wait_valid(n, ok);
    checks++;
    if (!ok || {result_cout, result} !== e2) begin
      errors++; $display("FAIL bp_second_result: got %b_%h, expected %b_%h",
                         result_cout, result, e2[WIDTH], e2[WIDTH-1:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit ok; bit seen; int n;
    out_ready = 1'b1;
    send(16'h1234, 16'h0F0F, 1'b0, ok);
    repeat (2) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, result_cout, result, add_a, add_b, add_cin} !==
        {1'b1, 1'b0, 1'b0, 1'b0, {WIDTH{1'b0}}, 4'h0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_values: got rdy=%b vld=%b busy=%b cout=%b res=%h a=%h b=%h cin=%b, expected 1 0 0 0 0 0 0 0",
               in_ready, out_valid, busy, result_cout, result, add_a, add_b, add_cin);
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL midreset_no_output: got out_valid pulse, expected none"); end
    send(16'h0001, 16'h0002, 1'b0, ok);
    wait_valid(n, ok);
    checks++;
    if (!ok || n != NIB || {result_cout, result} !== 17'h00003) begin
      errors++; $display("FAIL midreset_recover: got %b_%h after %0d edges, expected 0_0003 after %0d",
                         result_cout, result, n, NIB);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] sa[3];
    logic [WIDTH-1:0] sb[3];
    logic             sc[3];
    logic [WIDTH:0]   res_q[$];
    int               acc_edge[3];
    int               na;
    bit               rdy, v;
    logic [WIDTH:0]   snap, exp;
    for (int i = 0; i < 3; i++) begin
      sa[i] = WIDTH'($urandom); sb[i] = WIDTH'($urandom); sc[i] = 1'($urandom);
    end
    out_ready = 1'b1;
    na = 0;
    op_a = sa[0]; op_b = sb[0]; op_cin = sc[0]; in_valid = 1'b1;
    for (int k = 0; k < 80 && res_q.size() < 3; k++) begin
      rdy  = in_ready;
      v    = out_valid;
      snap = {result_cout, result};
      @(posedge clk); #1;
      if (v) res_q.push_back(snap);
      if (rdy && in_valid) begin
        acc_edge[na] = k;
        na++;
        if (na < 3) begin
          op_a = sa[na]; op_b = sb[na]; op_cin = sc[na];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (na != 3 || res_q.size() != 3) begin
      errors++; $display("FAIL b2b_count: got %0d accepts %0d results, expected 3 3", na, res_q.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc_edge[i] - acc_edge[i-1] != NIB + 2) begin
          errors++; $display("FAIL b2b_spacing%0d: got %0d edges, expected %0d",
                             i, acc_edge[i] - acc_edge[i-1], NIB + 2);
        end
      end
      for (int i = 0; i < 3; i++) begin
        exp = ref_add(sa[i], sb[i], sc[i]);
        checks++;
        if (res_q[i] !== exp) begin
          errors++; $display("FAIL b2b_result%0d: got %h, expected %h", i, res_q[i], exp);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_a = {WIDTH{1'b0}}; op_b = {WIDTH{1'b0}}; op_cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_basic();
    test_sequence();
    test_carry();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
